key_param_ctrl: RTL and testbench
=================================

# key_param_ctrl

Key-driven parameter controller for the OV5640 gray/Sobel/erosion/dilation video pipeline. Consumes debounced key events (one-cycle `key_flag` plus active-high `key_value`) from the key scan block and edits a shadow copy of the pipeline settings: display mode and Sobel threshold. Commits the shadow to the active outputs only at a frame boundary (VSYNC edge), so a frame never mixes two parameter sets. A timeout forces the commit when VSYNC is absent, for example when the camera is stalled.

## Interface
Parameters:
- `KEY_WIDTH`, 4, width of `key_value`; only bits [3:0] are decoded.
- `THRESH_DEFAULT`, 8'd64, Sobel threshold after reset or a restore-defaults key.
- `THRESH_STEP`, 8'd8, increment/decrement per key event.
- `THRESH_MIN`, 8'd8, lower saturation bound.
- `THRESH_MAX`, 8'd248, upper saturation bound.
- `VSYNC_POL`, 1'b1, active level of `frame_vsync`; the commit edge is the transition into the active level.
- `TIMEOUT_TOP`, 24'd10_000_000, cycles a pending change may wait for VSYNC before a forced commit.

Ports:
- `clk` in 1: system clock. `frame_vsync` is synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_flag` in 1: one-cycle strobe; `key_value` is valid in that cycle.
- `key_value` in KEY_WIDTH: pressed keys, active high.
- `frame_vsync` in 1: frame sync from the capture path.
- `mode_out` out 2: active display mode. 0 = GRAY, 1 = SOBEL, 2 = EROSION, 3 = DILATION.
- `sobel_threshold` out 8: active threshold.
- `param_update` out 1: one-cycle pulse in the cycle the active outputs change.
- `pending` out 1: high while the shadow differs from a committed state (dirty).

## Operation
Key decode, evaluated only when `key_flag`=1. Priority order:
- **Bit3 (restore defaults):** shadow mode = GRAY, shadow threshold = THRESH_DEFAULT. All other bits are ignored.
- **Bit0 (mode advance):** shadow mode follows GRAY→SOBEL→EROSION→DILATION→GRAY.
- **Bit1 (threshold up):** threshold = min(thr + STEP, THRESH_MAX).
  - Compute the sum in 9 bits so it cannot wrap.
- **Bit2 (threshold down):** threshold = max(thr − STEP, THRESH_MIN).
  - Compute with a signed/9-bit compare so it cannot underflow.
- **Bit1 and Bit2 together:** no threshold change. Bit0 in the same event still applies.
- **`key_flag` with no decoded bit set:** no effect; `pending` does not change.
- **Any decoded event sets `pending`**, even if saturation leaves the value unchanged.

Commit FSM, two states:
- **IDLE** (`pending`=0): the timeout counter is held at 0. A decoded key event moves the FSM to PEND.
- **PEND:** the timeout counter increments each cycle. A commit fires on the first of:
  - a VSYNC active edge (`vsync_d` inactive, `frame_vsync` active), or
  - timeout counter == TIMEOUT_TOP−1.
- **On commit:**
  - active ← shadow; `param_update`=1 for one cycle.
  - Counter cleared; return to IDLE.
- **Key event in the same cycle as a commit:**
  - The commit takes the pre-event shadow.
  - The shadow then takes the new value; the FSM stays in (or re-enters) PEND with the counter at 0.
- **VSYNC edge in IDLE:** no effect; no `param_update`.

Reset, mid-operation included:
- `mode_out`=0, `sobel_threshold`=THRESH_DEFAULT, `param_update`=0, `pending`=0.
- Shadow equals active; FSM = IDLE; counter = 0; `vsync_d` = inactive level.
- Reset discards any pending change.

## Timing
- Key event to shadow update: 1 cycle. Shadow values are internal, not visible on outputs.
- VSYNC edge to outputs: `frame_vsync` becomes active in cycle N. `mode_out`, `sobel_threshold` and `param_update` change at the clock edge ending cycle N, registered with `vsync_d` sampled at N−1.
- `param_update` always coincides with the first cycle of the new active values.
- `pending` rises 1 cycle after `key_flag` and falls in the same cycle `param_update` rises, unless a same-cycle key event keeps it high.
- Forced commit happens exactly TIMEOUT_TOP cycles after entry into PEND, or after the last key event that restarted the counter.
- `frame_vsync` must hold the active level for at least 1 cycle. Back-to-back edges give at most one commit per edge.

## Structure
- Package `key_param_pkg`: mode encodings (MODE_GRAY..MODE_DILATION), key bit indices (KEY_RESTORE=3, KEY_MODE=0, KEY_UP=1, KEY_DOWN=2), FSM state encodings (ST_IDLE, ST_PEND).
- One sub-module, `sync_edge_detect`: 1-bit register plus polarity parameter, producing a one-cycle active-edge pulse from `frame_vsync`.
- Top level: decode/shadow logic, commit FSM, 24-bit timeout counter, active output registers.

## Test plan
- **Reset, then an idle VSYNC pulse:** outputs stay mode 0 / threshold 64; `param_update` and `pending` stay 0.
- **Bit0 event, then a VSYNC edge 100 cycles later:**
  - `pending`=1 during the wait; `mode_out` changes 0→1 in the VSYNC edge cycle.
  - One `param_update` pulse; `pending`→0.
- **Bit1 events ×30, then VSYNC:** threshold saturates at 248. Then bit2 ×40, then VSYNC: threshold saturates at 8, with no wrap at any step.
- **Bit1 event, no VSYNC, TIMEOUT_TOP overridden to 1000:** commit exactly 1000 cycles after the event; threshold 72. A second key event at cycle 500 restarts the count.
- **Key event (bit0) in the same cycle as a VSYNC commit of an earlier bit1 change:**
  - The commit shows only the threshold change; `pending` stays 1.
  - The next VSYNC commits the mode change.
- **Bit3 with bit0|bit1 set, mode=2, threshold=200:**
  - After commit: mode 0, threshold 64.
  - Assert `rst_n` while pending: outputs return to defaults and no `param_update` fires.

Source files
------------

// File: rtl/key_param_pkg.sv
// Shared encodings for the key-driven pipeline parameter controller:
// display modes, key bit positions and commit FSM states.
package key_param_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY     = 2'd0,
    MODE_SOBEL    = 2'd1,
    MODE_EROSION  = 2'd2,
    MODE_DILATION = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam int KEY_MODE    = 0;
  localparam int KEY_UP      = 1;
  localparam int KEY_DOWN    = 2;
  localparam int KEY_RESTORE = 3;

endpackage

// File: rtl/sync_edge_detect.sv
// One-cycle pulse on the transition of sig_i into its active level (POL).
// The history register resets to the inactive level so a level held through reset is not an edge.
module sync_edge_detect #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= ~POL;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign edge_o = (sig_i == POL) && (sig_q != POL);

endmodule

// File: rtl/key_param_ctrl.sv
// Edits a shadow copy of display mode / Sobel threshold from key events and
// commits it to the active outputs on a VSYNC edge or after a stall timeout.
module key_param_ctrl
  import key_param_pkg::*;
#(
  parameter int          KEY_WIDTH      = 4,
  parameter logic [7:0]  THRESH_DEFAULT = 8'd64,
  parameter logic [7:0]  THRESH_STEP    = 8'd8,
  parameter logic [7:0]  THRESH_MIN     = 8'd8,
  parameter logic [7:0]  THRESH_MAX     = 8'd248,
  parameter logic        VSYNC_POL      = 1'b1,
  parameter logic [23:0] TIMEOUT_TOP    = 24'd10_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_flag,
  input  logic [KEY_WIDTH-1:0] key_value,
  input  logic                 frame_vsync,
  output logic [1:0]           mode_out,
  output logic [7:0]           sobel_threshold,
  output logic                 param_update,
  output logic                 pending
);

  mode_e       shadow_mode_q, shadow_mode_d, active_mode_q;
  logic [7:0]  shadow_thr_q, shadow_thr_d, active_thr_q;
  state_e      state_q;
  logic [23:0] cnt_q;
  logic        update_q;
  logic        key_event;
  logic        vsync_edge;
  logic        commit;
  logic [8:0]  sum9;

  sync_edge_detect #(
    .POL(VSYNC_POL)
  ) u_vsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (frame_vsync),
    .edge_o(vsync_edge)
  );

  // 9-bit arithmetic on both saturation paths so neither bound can wrap.
  always_comb begin
    sum9          = {1'b0, shadow_thr_q} + {1'b0, THRESH_STEP};
    key_event     = key_flag && (|key_value[3:0]);
    shadow_mode_d = shadow_mode_q;
    shadow_thr_d  = shadow_thr_q;
    if (key_event) begin
      if (key_value[KEY_RESTORE]) begin
        shadow_mode_d = MODE_GRAY;
        shadow_thr_d  = THRESH_DEFAULT;
      end else begin
        if (key_value[KEY_MODE]) begin
          shadow_mode_d = mode_e'(shadow_mode_q + 2'd1);
        end
        if (key_value[KEY_UP] && !key_value[KEY_DOWN]) begin
          shadow_thr_d = (sum9 > {1'b0, THRESH_MAX}) ? THRESH_MAX : sum9[7:0];
        end else if (key_value[KEY_DOWN] && !key_value[KEY_UP]) begin
          shadow_thr_d = ({1'b0, shadow_thr_q} < ({1'b0, THRESH_STEP} + {1'b0, THRESH_MIN}))
                         ? THRESH_MIN : (shadow_thr_q - THRESH_STEP);
        end
      end
    end
  end

  assign commit = (state_q == ST_PEND) && (vsync_edge || (cnt_q == TIMEOUT_TOP - 24'd1));

  // A key event coinciding with a commit wins the next state: the commit
  // takes the old shadow while the new edit re-arms PEND with a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_mode_q <= MODE_GRAY;
      shadow_thr_q  <= THRESH_DEFAULT;
      active_mode_q <= MODE_GRAY;
      active_thr_q  <= THRESH_DEFAULT;
      state_q       <= ST_IDLE;
      cnt_q         <= 24'd0;
      update_q      <= 1'b0;
    end else begin
      shadow_mode_q <= shadow_mode_d;
      shadow_thr_q  <= shadow_thr_d;
      update_q      <= commit;
      if (commit) begin
        active_mode_q <= shadow_mode_q;
        active_thr_q  <= shadow_thr_q;
      end
      if (key_event) begin
        state_q <= ST_PEND;
        cnt_q   <= 24'd0;
      end else if (commit) begin
        state_q <= ST_IDLE;
        cnt_q   <= 24'd0;
      end else if (state_q == ST_PEND) begin
        cnt_q <= cnt_q + 24'd1;
      end else begin
        cnt_q <= 24'd0;
      end
    end
  end

  assign mode_out        = active_mode_q;
  assign sobel_threshold = active_thr_q;
  assign param_update    = update_q;
  assign pending         = (state_q == ST_PEND);

endmodule

// File: tb/tb_key_param_ctrl.sv
// Directed bench for key_param_ctrl: vector table for edit/commit sequences,
// hand-written sequences for timeout, same-cycle key/commit and mid-run reset.
module tb_key_param_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_flag = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       frame_vsync = 1'b0;
  logic [1:0] mode_out;
  logic [7:0] sobel_threshold;
  logic       param_update;
  logic       pending;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] key;
    int         reps;
    int         wait_cyc;
    int         exp_mode;
    int         exp_thr;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  key_param_ctrl #(
    .TIMEOUT_TOP(24'd1000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_flag       (key_flag),
    .key_value      (key_value),
    .frame_vsync    (frame_vsync),
    .mode_out       (mode_out),
    .sobel_threshold(sobel_threshold),
    .param_update   (param_update),
    .pending        (pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_event(input logic [3:0] k);
    key_flag  = 1'b1;
    key_value = k;
    tick();
    key_flag  = 1'b0;
    key_value = 4'd0;
    tick();
  endtask

  task automatic vsync_commit(input string tag, input int em, input int et);
    frame_vsync = 1'b1;
    tick();
    chk({tag, " param_update"}, param_update, 1);
    chk({tag, " mode_out"}, mode_out, em);
    chk({tag, " threshold"}, sobel_threshold, et);
    chk({tag, " pending clear"}, pending, 0);
    tick();
    chk({tag, " single pulse"}, param_update, 0);
    frame_vsync = 1'b0;
    tick();
  endtask

  task automatic wait_update(output int n);
    n = 0;
    while (param_update !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    key_flag    = 1'b0;
    key_value   = 4'd0;
    frame_vsync = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;

    vecs[0] = '{4'b0001, 1, 100, 1, 64};
    vecs[1] = '{4'b0010, 30, 0, 1, 248};
    vecs[2] = '{4'b0100, 40, 0, 1, 8};
    vecs[3] = '{4'b0011, 1, 0, 2, 16};
    vecs[4] = '{4'b0111, 1, 0, 3, 16};
    vecs[5] = '{4'b0001, 1, 0, 0, 16};
    vecs[6] = '{4'b0110, 1, 0, 0, 16};
    vecs[7] = '{4'b0001, 2, 0, 2, 16};
    vecs[8] = '{4'b0010, 23, 0, 2, 200};
    vecs[9] = '{4'b1011, 1, 0, 0, 64};

    // Reset state
    tick();
    chk("reset mode", mode_out, 0);
    chk("reset threshold", sobel_threshold, 64);
    chk("reset update", param_update, 0);
    chk("reset pending", pending, 0);
    rst_n = 1'b1;
    tick();

    // VSYNC while idle does nothing
    frame_vsync = 1'b1;
    tick();
    chk("idle vsync update", param_update, 0);
    chk("idle vsync mode", mode_out, 0);
    chk("idle vsync threshold", sobel_threshold, 64);
    frame_vsync = 1'b0;
    tick();
    chk("idle vsync pending", pending, 0);

    // key_flag without a decoded bit
    key_event(4'b0000);
    chk("empty key pending", pending, 0);
    $display("txn idle-vsync and empty-key done");

    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) key_event(vecs[i].key);
      repeat (vecs[i].wait_cyc) tick();
      chk($sformatf("vec%0d pending", i), pending, 1);
      vsync_commit($sformatf("vec%0d", i), vecs[i].exp_mode, vecs[i].exp_thr);
      $display("txn vec%0d key=%b x%0d -> mode=%0d thr=%0d", i, vecs[i].key, vecs[i].reps,
               mode_out, sobel_threshold);
    end

    // Forced commit after TIMEOUT_TOP cycles with no VSYNC
    do_reset();
    key_flag  = 1'b1;
    key_value = 4'b0010;
    tick();
    key_flag  = 1'b0;
    key_value = 4'd0;
    wait_update(n);
    chk("timeout latency", n, 1000);
    chk("timeout threshold", sobel_threshold, 72);
    chk("timeout pending", pending, 0);
    $display("txn timeout commit after %0d cycles thr=%0d", n, sobel_threshold);

    // Second key at cycle 500 restarts the count
    tick();
    key_flag  = 1'b1;
    key_value = 4'b0010;
    tick();
    key_flag  = 1'b0;
    key_value = 4'd0;
    repeat (499) tick();
    chk("restart no early update", param_update, 0);
    chk("restart pending", pending, 1);
    key_flag  = 1'b1;
    key_value = 4'b0010;
    tick();
    key_flag  = 1'b0;
    key_value = 4'd0;
    wait_update(n);
    chk("restart latency", n, 1000);
    chk("restart threshold", sobel_threshold, 88);
    $display("txn restarted timeout commit after %0d cycles thr=%0d", n, sobel_threshold);
    tick();

    // Key event in the same cycle as a VSYNC commit
    key_event(4'b0010);
    frame_vsync = 1'b1;
    key_flag    = 1'b1;
    key_value   = 4'b0001;
    tick();
    key_flag  = 1'b0;
    key_value = 4'd0;
    chk("same-cycle update", param_update, 1);
    chk("same-cycle threshold", sobel_threshold, 96);
    chk("same-cycle mode", mode_out, 0);
    chk("same-cycle pending", pending, 1);
    frame_vsync = 1'b0;
    tick();
    chk("same-cycle single pulse", param_update, 0);
    vsync_commit("same-cycle follow-up", 1, 96);
    $display("txn same-cycle key/commit mode=%0d thr=%0d", mode_out, sobel_threshold);

    // Reset while a change is pending
    key_event(4'b0011);
    chk("pre-reset pending", pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset mode", mode_out, 0);
    chk("async reset threshold", sobel_threshold, 64);
    chk("async reset pending", pending, 0);
    chk("async reset update", param_update, 0);
    tick();
    rst_n = 1'b1;
    tick();
    frame_vsync = 1'b1;
    tick();
    chk("post-reset vsync update", param_update, 0);
    chk("post-reset vsync mode", mode_out, 0);
    chk("post-reset vsync threshold", sobel_threshold, 64);
    frame_vsync = 1'b0;
    tick();
    $display("txn reset while pending mode=%0d thr=%0d", mode_out, sobel_threshold);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
